// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: bus widths, loader FSM states and error codes.
package sap1_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         DEF_TIMEOUT   = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DONE
  } ld_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/sap1_timeout_cnt.sv
// Idle-cycle counter: clear restarts it, enable advances it, terminal count
// fires on the enabled cycle that would bring the count up to LIMIT.
module sap1_timeout_cnt #(
  parameter int LIMIT = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  assign tc_o = en_i && (count_reg == LAST);

  // Count idle cycles; hold at the terminal value until cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_reg <= '0;
    end else if (en_i && !tc_o) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/sap1_ram_loader.sv
// Framed byte-stream loader that checks and writes a program into the
// SAP-1 16x8 RAM. Frame: SYNC, LEN, LEN data bytes, CHK.
module sap1_ram_loader #(
  parameter int          ADDR_W    = sap1_pkg::ADDR_W,
  parameter int          DATA_W    = sap1_pkg::DATA_W,
  parameter int          DEPTH     = sap1_pkg::DEPTH,
  parameter logic [7:0]  SYNC_BYTE = sap1_pkg::DEF_SYNC_BYTE,
  parameter int          TIMEOUT   = sap1_pkg::DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              prog_valid_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  import sap1_pkg::*;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  ld_state_t state_reg, state_next;

  logic [DATA_W-1:0] acc_reg;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   len_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              err_reg;
  logic [1:0]        err_code_reg;
  logic              prog_valid_reg;

  logic              accept;
  logic              len_bad;
  logic              last_data;
  logic [DATA_W-1:0] chk_sum;
  logic              tmo_tc;
  logic              start;
  logic              pass;
  logic              set_err;
  logic [1:0]        err_code_next;

  // Ready is dropped for the single DONE cycle and while reset is held.
  assign s_ready_o = (state_reg != ST_DONE) && !rst_i;
  assign accept    = s_valid_i && s_ready_o;
  assign busy_o    = (state_reg == ST_LEN) || (state_reg == ST_DATA) || (state_reg == ST_CHK);
  assign done_o    = (state_reg == ST_DONE);

  assign len_bad   = (s_data_i == '0) || (s_data_i > DATA_W'(DEPTH));
  assign last_data = (cnt_reg + CNT_ONE) == len_reg;
  assign chk_sum   = acc_reg + s_data_i;

  assign wr_en_o      = wr_en_reg;
  assign wr_addr_o    = wr_addr_reg;
  assign wr_data_o    = wr_data_reg;
  assign err_o        = err_reg;
  assign err_code_o   = err_code_reg;
  assign prog_valid_o = prog_valid_reg;

  // Idle timer runs only inside a frame and restarts on every accepted byte.
  sap1_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!busy_o || accept),
    .en_i  (busy_o && !accept),
    .tc_o  (tmo_tc)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode plus one-cycle control strobes for the datapath.
  always_comb begin
    state_next    = state_reg;
    start         = 1'b0;
    pass          = 1'b0;
    set_err       = 1'b0;
    err_code_next = ERR_NONE;
    case (state_reg)
      ST_IDLE: begin
        if (accept && (s_data_i == SYNC_BYTE)) begin
          state_next = ST_LEN;
          start      = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_next    = ST_IDLE;
            set_err       = 1'b1;
            err_code_next = ERR_LEN;
          end else begin
            state_next = ST_DATA;
          end
        end else if (tmo_tc) begin
          state_next    = ST_IDLE;
          set_err       = 1'b1;
          err_code_next = ERR_TMO;
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (last_data) begin
            state_next = ST_CHK;
          end
        end else if (tmo_tc) begin
          state_next    = ST_IDLE;
          set_err       = 1'b1;
          err_code_next = ERR_TMO;
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (chk_sum == '0) begin
            state_next = ST_DONE;
            pass       = 1'b1;
          end else begin
            state_next    = ST_IDLE;
            set_err       = 1'b1;
            err_code_next = ERR_CHK;
          end
        end else if (tmo_tc) begin
          state_next    = ST_IDLE;
          set_err       = 1'b1;
          err_code_next = ERR_TMO;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Checksum, length, write register and sticky status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      len_reg        <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
      prog_valid_reg <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      if (start) begin
        acc_reg        <= '0;
        cnt_reg        <= '0;
        err_reg        <= 1'b0;
        err_code_reg   <= ERR_NONE;
        prog_valid_reg <= 1'b0;
      end
      if ((state_reg == ST_LEN) && accept && !len_bad) begin
        len_reg <= s_data_i[ADDR_W:0];
      end
      if ((state_reg == ST_DATA) && accept) begin
        acc_reg     <= acc_reg + s_data_i;
        cnt_reg     <= cnt_reg + CNT_ONE;
        wr_en_reg   <= 1'b1;
        wr_addr_reg <= cnt_reg[ADDR_W-1:0];
        wr_data_reg <= s_data_i;
      end
      if (set_err) begin
        err_reg      <= 1'b1;
        err_code_reg <= err_code_next;
      end
      if (pass) begin
        prog_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sap1_ram_loader.sv
// Self-checking bench for sap1_ram_loader: expected RAM writes are queued as
// data bytes are driven and matched against the write port as it fires.
module tb_sap1_ram_loader;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       prog_valid;
  logic       err;
  logic [1:0] err_code;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         wr_cyc[$];
  logic [7:0] dq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rdy_lo = 0;
  int d0;
  int r0;

  sap1_ram_loader #(
    .TIMEOUT (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .busy_o       (busy),
    .done_o       (done),
    .prog_valid_o (prog_valid),
    .err_o        (err),
    .err_code_o   (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port scoreboard and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (!rst && !s_ready) rdy_lo++;
    if (done) done_cnt++;
    if (wr_en) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected_pending", exp_q.size(), 1);
      end else begin
        w = exp_q.pop_front();
        check_eq("wr_addr", wr_addr, w.a);
        check_eq("wr_data", wr_data, w.d);
        $display("write addr=%0h data=%02h", wr_addr, wr_data);
      end
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte after an optional gap and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_data, input logic [3:0] a);
    bit ok;
    wr_t w;
    if (gap > 0) idle(gap);
    s_data  = b;
    s_valid = 1'b1;
    if (is_data) begin
      w.a = a;
      w.d = b;
      exp_q.push_back(w);
    end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("ready_wait", ok, 1);
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] d[$], input logic [7:0] chk, input int gmax);
    send_byte(8'hA5, $urandom_range(gmax, 0), 1'b0, 4'd0);
    send_byte(len, $urandom_range(gmax, 0), 1'b0, 4'd0);
    for (int i = 0; i < d.size(); i++) begin
      send_byte(d[i], $urandom_range(gmax, 0), 1'b1, 4'(i));
    end
    send_byte(chk, $urandom_range(gmax, 0), 1'b0, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", s_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_prog", prog_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_code", err_code, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", s_ready, 1);

    // Nominal frame, valid held high
    wr_cyc.delete();
    d0 = done_cnt;
    r0 = rdy_lo;
    dq = {8'h10, 8'h20, 8'h30};
    send_frame(8'h03, dq, 8'hA0, 0);
    idle(4);
    check_eq("nom_done", done_cnt - d0, 1);
    check_eq("nom_prog", prog_valid, 1);
    check_eq("nom_err", err, 0);
    check_eq("nom_rdy_lo", rdy_lo - r0, 1);
    check_eq("nom_nwr", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      check_eq("nom_b2b_1", wr_cyc[1] - wr_cyc[0], 1);
      check_eq("nom_b2b_2", wr_cyc[2] - wr_cyc[1], 1);
    end
    $display("nominal frame: done=%0d prog_valid=%0d", done_cnt - d0, prog_valid);

    // Checksum failure
    d0 = done_cnt;
    dq = {8'h01, 8'h02};
    send_frame(8'h02, dq, 8'h00, 0);
    idle(4);
    check_eq("chk_err", err, 1);
    check_eq("chk_code", err_code, 2);
    check_eq("chk_prog", prog_valid, 0);
    check_eq("chk_done", done_cnt - d0, 0);
    check_eq("chk_sb", exp_q.size(), 0);
    $display("checksum frame: err=%0d code=%0d", err, err_code);

    // Bad lengths, then recovery
    send_byte(8'hA5, 0, 1'b0, 4'd0);
    check_eq("len0_clr", err, 0);
    send_byte(8'h00, 0, 1'b0, 4'd0);
    idle(2);
    check_eq("len0_err", err, 1);
    check_eq("len0_code", err_code, 1);
    check_eq("len0_busy", busy, 0);
    send_byte(8'hA5, 0, 1'b0, 4'd0);
    check_eq("len17_clr", err, 0);
    send_byte(8'h11, 0, 1'b0, 4'd0);
    idle(2);
    check_eq("len17_err", err, 1);
    check_eq("len17_code", err_code, 1);
    d0 = done_cnt;
    dq = {8'h7F};
    send_frame(8'h01, dq, 8'h81, 0);
    idle(3);
    check_eq("rec_err", err, 0);
    check_eq("rec_prog", prog_valid, 1);
    check_eq("rec_done", done_cnt - d0, 1);
    $display("bad length recovery: err=%0d prog_valid=%0d", err, prog_valid);

    // Timeout inside DATA
    send_byte(8'hA5, 0, 1'b0, 4'd0);
    send_byte(8'h02, 0, 1'b0, 4'd0);
    send_byte(8'h55, 0, 1'b1, 4'd0);
    s_valid = 1'b0;
    repeat (TMO - 1) begin
      @(posedge clk);
      #1;
    end
    check_eq("tmo_early_err", err, 0);
    check_eq("tmo_early_busy", busy, 1);
    @(posedge clk);
    #1;
    check_eq("tmo_err", err, 1);
    check_eq("tmo_code", err_code, 3);
    check_eq("tmo_busy", busy, 0);
    send_byte(8'h66, 2, 1'b0, 4'd0);
    idle(3);
    check_eq("tmo_idle_busy", busy, 0);
    check_eq("tmo_sticky", err_code, 3);
    check_eq("tmo_sb", exp_q.size(), 0);
    $display("timeout: err=%0d code=%0d", err, err_code);

    // Leading garbage with random valid gaps
    d0 = done_cnt;
    send_byte(8'h00, $urandom_range(3, 0), 1'b0, 4'd0);
    send_byte(8'hFF, $urandom_range(3, 0), 1'b0, 4'd0);
    dq = {8'h7F};
    send_frame(8'h01, dq, 8'h81, 3);
    idle(4);
    check_eq("gap_done", done_cnt - d0, 1);
    check_eq("gap_prog", prog_valid, 1);
    check_eq("gap_err", err, 0);
    $display("garbage+gaps: done=%0d", done_cnt - d0);

    // Reset during the second data byte
    send_byte(8'hA5, 0, 1'b0, 4'd0);
    send_byte(8'h03, 0, 1'b0, 4'd0);
    send_byte(8'h11, 0, 1'b1, 4'd0);
    s_data  = 8'h22;
    s_valid = 1'b1;
    rst     = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready", s_ready, 0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_wr_en", wr_en, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_err", err, 0);
    check_eq("mid_rst_prog", prog_valid, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_addr", wr_addr, 0);
    rst     = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", s_ready, 1);
    check_eq("post_rst_wr_en", wr_en, 0);
    d0 = done_cnt;
    dq = {8'h01, 8'h02};
    send_frame(8'h02, dq, 8'hFD, 1);
    idle(4);
    check_eq("post_rst_done", done_cnt - d0, 1);
    check_eq("post_rst_prog", prog_valid, 1);
    $display("reset mid-frame: reload done=%0d", done_cnt - d0);

    check_eq("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sap1_ram_loader.md
Name: sap1_ram_loader

Overview:
- Write-side counterpart to the SAP-1 program RAM read path.
- Accepts a framed byte stream on a valid/ready interface, checks it, and writes the program into the 16x8 RAM at addresses 0..LEN-1.
- Top level holds the CPU (controller/PC) in reset while busy_o is high, and only releases it once prog_valid_o is set.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word and stream byte width.
- DEPTH, 16, number of RAM words (2**ADDR_W).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 50000, maximum idle cycles between bytes inside a frame.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- s_data_i  in  DATA_W  stream byte.
- s_valid_i  in  1  stream byte valid.
- s_ready_o  out  1  loader can accept a byte.
- wr_en_o  out  1  RAM write strobe, one cycle per word.
- wr_addr_o  out  ADDR_W  RAM write address.
- wr_data_o  out  DATA_W  RAM write data.
- busy_o  out  1  frame in progress (states LEN/DATA/CHK).
- done_o  out  1  one-cycle pulse when a frame passes its checksum.
- prog_valid_o  out  1  RAM holds a verified program.
- err_o  out  1  sticky error flag.
- err_code_o  out  2  error cause: 0 none, 1 bad length, 2 checksum, 3 timeout.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0 and state IDLE. s_ready_o is 0 during the reset cycle and 1 from the first cycle after rst_i deasserts.
- A byte transfers on a cycle where s_valid_i and s_ready_o are both high.
- s_ready_o is 1 in every state except DONE. DONE lasts one cycle, so s_ready_o is 0 for exactly that cycle.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CHK.
  - LEN is valid for 1..DEPTH only.
  - Pass condition: (sum of data bytes + CHK) mod 256 == 0.
- FSM states: IDLE, LEN, DATA, CHK, DONE.
  - IDLE: a non-SYNC byte is accepted and discarded. A SYNC byte moves to LEN, clears err_o, err_code_o and prog_valid_o, clears the checksum accumulator, and sets the address counter to 0.
  - LEN: if LEN is 0 or greater than DEPTH, set err_o with code 1 and go to IDLE. Otherwise latch LEN and go to DATA.
  - DATA: each accepted byte is added to the accumulator (mod 256) and causes one RAM write. After the LEN-th byte, go to CHK.
  - CHK: on the accepted byte, check the pass condition. Pass goes to DONE. Fail sets err_o with code 2 and goes to IDLE; the RAM already holds the partial data and prog_valid_o stays 0.
  - DONE: done_o=1 for this cycle, prog_valid_o set to 1, then IDLE.
- Write latency: a data byte accepted in cycle N gives wr_en_o=1 in cycle N+1, with registered wr_addr_o and wr_data_o.
  - wr_addr_o starts at 0 and increments after each write.
  - Back-to-back bytes give back-to-back writes.
  - wr_en_o is never asserted outside DATA-driven writes.
- Timeout:
  - In LEN, DATA and CHK, a counter counts cycles with no accepted byte, and resets to 0 on each accepted byte.
  - When it reaches TIMEOUT: set err_o with code 3 and go to IDLE.
  - The counter is inactive in IDLE.
- busy_o = 1 exactly while in LEN, DATA or CHK.
- SYNC_BYTE seen mid-frame is treated as ordinary data; there is no resync.
- Reset mid-frame: immediate return to IDLE and all outputs 0. A write registered in the same cycle as rst_i is suppressed. RAM contents are not touched.
- err_o is sticky until the next SYNC_BYTE or reset. prog_valid_o holds until the next SYNC_BYTE or reset.

Decomposition:
- Shared package sap1_pkg:
  - state enum for the loader FSM
  - err_code constants (ERR_NONE, ERR_LEN, ERR_CHK, ERR_TMO)
  - default SYNC_BYTE
  - ADDR_W and DATA_W shared with the RAM, MAR and PC
- One sub-module: sap1_timeout_cnt, a loadable idle counter with clear/enable and a terminal-count output.
- FSM, checksum and write register stay in sap1_ram_loader.

Test Plan:
- Nominal frame A5,03,10,20,30,A0 with valid held high: writes (0,10),(1,20),(2,30) on consecutive cycles; done_o pulses once; prog_valid_o=1; err_o=0; s_ready_o=0 for one cycle.
- Checksum failure A5,02,01,02,00: two writes occur; err_o=1, err_code_o=2, prog_valid_o=0, no done_o pulse.
- Bad length A5,00 and, after recovery, A5,11: err_code_o=1 both times; no writes; a following valid frame clears err_o.
- Timeout with TIMEOUT=8: send A5,02,55, then idle 8 cycles: err_code_o=3; a later byte 66 is discarded in IDLE with no write.
- Leading garbage and valid gaps: bytes 00,FF before A5,01,7F,81 with random s_valid_i gaps: garbage ignored; one write (0,7F); done_o pulses.
- Reset mid-frame: assert rst_i in the same cycle as the second data byte is accepted: no write for that byte, all outputs 0, busy_o=0; a fresh frame afterwards loads correctly.
